// File: rtl/spi_slave_fsm.sv
// Transaction sequencer for the SPI slave: walks address, R/W and data phases of a
// frame and issues one-cycle enables to the address latch, shift register and data memory.
module spi_slave_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic sclk_posedge,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_load,
    output logic dm_we,
    output logic miso_en,
    output logic done
);

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        LATCH_ADDR,
        READ_WAIT,
        READ_LOAD,
        READ_SEND,
        WRITE_GET,
        WRITE_MEM,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Chip-select release aborts any frame in flight, ahead of strobe handling.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state != IDLE && cs_n) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_n) begin
                        state_next = GET_ADDR;
                        cnt_next   = '0;
                    end
                end
                GET_ADDR: begin
                    if (sclk_posedge) begin
                        if (cnt == ADDR_LAST) begin
                            state_next = LATCH_ADDR;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CNT_ONE;
                        end
                    end
                end
                LATCH_ADDR: state_next = rw_bit ? READ_WAIT : WRITE_GET;
                READ_WAIT:  state_next = READ_LOAD;
                READ_LOAD: begin
                    state_next = READ_SEND;
                    cnt_next   = '0;
                end
                READ_SEND, WRITE_GET: begin
                    if (sclk_posedge) begin
                        if (cnt == DATA_LAST) begin
                            state_next = (state == READ_SEND) ? DONE : WRITE_MEM;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CNT_ONE;
                        end
                    end
                end
                WRITE_MEM: state_next = DONE;
                DONE:      state_next = DONE;
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Moore outputs: decoded from the registered state only.
    always_comb begin
        addr_we = 1'b0;
        sr_load = 1'b0;
        dm_we   = 1'b0;
        miso_en = 1'b0;
        done    = 1'b0;
        case (state)
            LATCH_ADDR: addr_we = 1'b1;
            READ_LOAD:  sr_load = 1'b1;
            READ_SEND:  miso_en = 1'b1;
            WRITE_MEM:  dm_we   = 1'b1;
            DONE:       done    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: table of frame steps plus hand-written abort and reset sequences.
module tb_spi_slave_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs_n = 1'b1;
    logic sclk_posedge = 1'b0;
    logic rw_bit = 1'b0;
    logic addr_we, sr_load, dm_we, miso_en, done;

    int errors = 0;
    int checks = 0;

    int n_addr = 0, n_sr = 0, n_dm = 0, n_miso = 0, n_multi = 0;

    spi_slave_fsm #(.ADDR_BITS(7), .DATA_BITS(8), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .cs_n(cs_n),
        .sclk_posedge(sclk_posedge),
        .rw_bit(rw_bit),
        .addr_we(addr_we),
        .sr_load(sr_load),
        .dm_we(dm_we),
        .miso_en(miso_en),
        .done(done)
    );

    always #5 clk = ~clk;

    // Pulse accounting, sampled mid-cycle.
    always @(negedge clk) begin
        n_addr = n_addr + int'(addr_we);
        n_sr   = n_sr + int'(sr_load);
        n_dm   = n_dm + int'(dm_we);
        n_miso = n_miso + int'(miso_en);
        if (int'(addr_we) + int'(sr_load) + int'(dm_we) > 1) n_multi = n_multi + 1;
    end

    typedef struct {
        string      name;
        logic       rst;
        logic       csn;
        logic       rw;
        int         nstb;
        int         idle;
        logic [4:0] exp;   // {addr_we, sr_load, dm_we, miso_en, done}
    } step_t;

    step_t tab[21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_n(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (9) tick();
            sclk_posedge = 1'b1;
            tick();
            sclk_posedge = 1'b0;
        end
    endtask

    task automatic check_out(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {addr_we, sr_load, dm_we, miso_en, done};
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: outputs {addr_we,sr_load,dm_we,miso_en,done} got %b expected %b",
                     name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_step(input int i);
        reset  = tab[i].rst;
        cs_n   = tab[i].csn;
        rw_bit = tab[i].rw;
        strobe_n(tab[i].nstb);
        repeat (tab[i].idle) tick();
        check_out(tab[i].name, tab[i].exp);
    endtask

    int a0, s0, d0, m0;

    initial begin
        // Write frame, stray strobes in DONE, 2-cycle gap, then read frame.
        tab[0]  = '{"reset",      1'b1, 1'b1, 1'b0, 0, 2, 5'b00000};
        tab[1]  = '{"w_cs_low",   1'b0, 1'b0, 1'b0, 0, 1, 5'b00000};
        tab[2]  = '{"w_addr7",    1'b0, 1'b0, 1'b0, 7, 9, 5'b00000};
        tab[3]  = '{"w_addr8",    1'b0, 1'b0, 1'b0, 1, 0, 5'b10000};
        tab[4]  = '{"w_get",      1'b0, 1'b0, 1'b0, 0, 8, 5'b00000};
        tab[5]  = '{"w_data7",    1'b0, 1'b0, 1'b0, 7, 9, 5'b00000};
        tab[6]  = '{"w_data8",    1'b0, 1'b0, 1'b0, 1, 0, 5'b00100};
        tab[7]  = '{"w_done",     1'b0, 1'b0, 1'b0, 0, 1, 5'b00001};
        tab[8]  = '{"w_hold",     1'b0, 1'b0, 1'b0, 0, 5, 5'b00001};
        tab[9]  = '{"w_stray",    1'b0, 1'b0, 1'b0, 5, 1, 5'b00001};
        tab[10] = '{"gap1",       1'b0, 1'b1, 1'b0, 0, 1, 5'b00000};
        tab[11] = '{"gap2",       1'b0, 1'b1, 1'b0, 0, 1, 5'b00000};
        tab[12] = '{"r_cs_low",   1'b0, 1'b0, 1'b1, 0, 1, 5'b00000};
        tab[13] = '{"r_addr7",    1'b0, 1'b0, 1'b1, 7, 9, 5'b00000};
        tab[14] = '{"r_addr8",    1'b0, 1'b0, 1'b1, 1, 0, 5'b10000};
        tab[15] = '{"r_wait",     1'b0, 1'b0, 1'b1, 0, 1, 5'b00000};
        tab[16] = '{"r_load",     1'b0, 1'b0, 1'b1, 0, 1, 5'b01000};
        tab[17] = '{"r_send",     1'b0, 1'b0, 1'b1, 0, 1, 5'b00010};
        tab[18] = '{"r_data7",    1'b0, 1'b0, 1'b1, 7, 9, 5'b00010};
        tab[19] = '{"r_data8",    1'b0, 1'b0, 1'b1, 1, 0, 5'b00001};
        tab[20] = '{"r_end",      1'b0, 1'b1, 1'b1, 0, 1, 5'b00000};

        run_step(0);
        a0 = n_addr; s0 = n_sr; d0 = n_dm; m0 = n_miso;
        for (int i = 1; i < 10; i++) run_step(i);
        check_int("write_addr_we_pulses", n_addr - a0, 1);
        check_int("write_dm_we_pulses",   n_dm - d0,   1);
        check_int("write_sr_load_pulses", n_sr - s0,   0);
        check_int("write_miso_cycles",    n_miso - m0, 0);
        m0 = n_miso;
        for (int i = 10; i < 21; i++) run_step(i);
        check_int("b2b_addr_we_pulses", n_addr - a0, 2);
        check_int("b2b_sr_load_pulses", n_sr - s0,   1);
        check_int("b2b_dm_we_pulses",   n_dm - d0,   1);
        check_int("read_miso_cycles_nonzero", int'(n_miso - m0 > 0), 1);

        // CS abort after address strobe 5, then a clean write frame.
        cs_n = 1'b0; rw_bit = 1'b0;
        tick();
        strobe_n(5);
        repeat (4) tick();
        cs_n = 1'b1;
        tick();
        check_out("abort_idle", 5'b00000);
        repeat (2) tick();
        cs_n = 1'b0;
        tick();
        strobe_n(7);
        repeat (9) tick();
        check_out("abort_new_addr7", 5'b00000);
        strobe_n(1);
        check_out("abort_new_addr8", 5'b10000);
        repeat (8) tick();
        strobe_n(8);
        check_out("abort_new_dm_we", 5'b00100);
        tick();
        check_out("abort_new_done", 5'b00001);
        cs_n = 1'b1;
        tick();
        check_out("abort_new_idle", 5'b00000);

        // Reset in the middle of a read send phase.
        cs_n = 1'b0; rw_bit = 1'b1;
        tick();
        strobe_n(8);
        check_out("rst_read_addr_we", 5'b10000);
        repeat (4) tick();
        strobe_n(3);
        check_out("rst_read_sending", 5'b00010);
        reset = 1'b1;
        tick();
        check_out("rst_read_cleared", 5'b00000);
        reset = 1'b0;
        s0 = n_sr; d0 = n_dm;
        repeat (20) tick();
        check_out("rst_read_after", 5'b00000);
        check_int("rst_read_no_sr_load", n_sr - s0, 0);
        check_int("rst_read_no_dm_we",   n_dm - d0, 0);
        cs_n = 1'b1;
        tick();

        check_int("enables_mutually_exclusive", n_multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
